// File: rtl/sram_pipe_array.sv
// Single-port synchronous SRAM model with req/ready handshake, byte enables, RD_LAT read pipe,
// post-reset zero-fill and out-of-range detection. Optional per-byte parity via SRAM_PARITY_EN.
//
// state  | meaning
// S_INIT | zero-fill sweep over 0..DEPTH-1, one word per cycle; ready=0
// S_IDLE | sweep finished; ready=1, one access accepted per cycle
module sram_pipe_array #(
    parameter int DW     = 32,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB    = DW / 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req,
    output logic          ready,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [NB-1:0] be,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          rvalid,
    output logic          addr_err,
    output logic          init_done,
    output logic          par_err
);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
    localparam logic [AW:0] LAST_V  = DEPTH_V - 1'b1;

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt, init_cnt_nxt;
    logic          init_we;

    logic [DW-1:0] mem [DEPTH];

    logic          in_range, acc, wr_acc, rd_acc;
    logic [DW-1:0] rd_word;
    logic          rd_par_bad;

    logic [RD_LAT-1:0] vld_q, err_q, perr_q;
    logic [DW-1:0]     dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        init_we      = 1'b0;
        case (state)
            S_INIT: begin
                init_we = 1'b1;
                if ({1'b0, init_cnt} == LAST_V)
                    state_nxt = S_IDLE;
                else
                    init_cnt_nxt = init_cnt + 1'b1;
            end
            S_IDLE: ;
            default: state_nxt = S_INIT;
        endcase
    end

    assign ready     = (state == S_IDLE);
    assign init_done = (state == S_IDLE);

    assign in_range = ({1'b0, addr} < DEPTH_V);
    assign acc      = req && ready;
    assign wr_acc   = acc && we && in_range;
    assign rd_acc   = acc && !we;
    assign rd_word  = in_range ? mem[addr] : '0;

    // Array is deliberately not reset: the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (init_we) begin
            par_mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) par_mem[addr][i] <= ^din[8*i +: 8];
        end
    end

    always_comb begin
        rd_par_bad = 1'b0;
        if (in_range)
            for (int i = 0; i < NB; i++)
                if (par_mem[addr][i] != ^mem[addr][8*i +: 8]) rd_par_bad = 1'b1;
    end

    // Simulation hook: corrupts the stored parity bit of one byte.
    task automatic inject_par_flip(input logic [AW-1:0] a, input int b);
        par_mem[a][b] = ~par_mem[a][b];
    endtask
`else
    assign rd_par_bad = 1'b0;
`endif

    // Data stages only advance behind a valid so dout holds the last read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= '0;
            err_q  <= '0;
            perr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0]  <= rd_acc;
            err_q[0]  <= acc && !in_range;
            perr_q[0] <= rd_acc && rd_par_bad;
            if (rd_acc) dat_q[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                perr_q[i] <= perr_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rvalid   = vld_q[RD_LAT-1];
    assign addr_err = err_q[RD_LAT-1];
    assign par_err  = perr_q[RD_LAT-1];
    assign dout     = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_sram_pipe_array.sv
// Randomised self-checking bench for sram_pipe_array against a cycle-slotted behavioural model.
// DEPTH=12 so that the 4-bit address space reaches out-of-range words.
module tb_sram_pipe_array;

    localparam int DW     = 32;
    localparam int DEPTH  = 12;
    localparam int RD_LAT = 2;
    localparam int AW     = 4;
    localparam int NB     = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [NB-1:0] be = '0;
    logic [DW-1:0] din = '0;
    logic          ready, rvalid, addr_err, init_done, par_err;
    logic [DW-1:0] dout;

    sram_pipe_array #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rstn(rstn), .req(req), .ready(ready), .we(we), .addr(addr),
        .be(be), .din(din), .dout(dout), .rvalid(rvalid), .addr_err(addr_err),
        .init_done(init_done), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: word array plus a ring of expected outputs indexed by clock-edge number.
    logic [DW-1:0] m_mem  [DEPTH];
    logic [NB-1:0] m_pbad [DEPTH];
    int            init_cnt = 0;
    int            edge_n = 0;
    bit            ev_m [8];
    bit            ee_m [8];
    bit            ep_m [8];
    logic [DW-1:0] ed_m [8];
    logic [DW-1:0] hold = '0;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            ev_m[i] = 0; ee_m[i] = 0; ep_m[i] = 0; ed_m[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0; m_pbad[i] = '0;
        end
        init_cnt = 0;
    endtask

    initial model_clear();

    always @(negedge rstn) model_clear();

    always @(posedge clk) begin
        int s, a;
        edge_n++;
        s = (edge_n + RD_LAT - 1) % 8;
        ev_m[s] = 0; ee_m[s] = 0; ep_m[s] = 0; ed_m[s] = '0;
        if (rstn) begin
            if (init_cnt >= DEPTH && req) begin
                a = int'(addr);
                if (a >= DEPTH) begin
                    ee_m[s] = 1;
                    ev_m[s] = !we;
                end else if (we) begin
                    for (int b = 0; b < NB; b++)
                        if (be[b]) begin
                            m_mem[a][8*b +: 8] = din[8*b +: 8];
                            m_pbad[a][b] = 1'b0;
                        end
                end else begin
                    ev_m[s] = 1;
                    ed_m[s] = m_mem[a];
                    ep_m[s] = |m_pbad[a];
                end
            end
            if (init_cnt < DEPTH) init_cnt++;
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          rv;
        logic          er;
        logic          pe;
    } evt_t;
    evt_t ev_q[$];

    always @(negedge clk) begin
        int s;
        bit rdy;
        s = edge_n % 8;
        rdy = rstn && (init_cnt >= DEPTH);
        if (!rstn) hold = '0;
        if (ev_m[s]) hold = ed_m[s];
        chk("ready", 32'(ready), 32'(rdy));
        chk("init_done", 32'(init_done), 32'(rdy));
        chk("rvalid", 32'(rvalid), 32'(ev_m[s]));
        chk("addr_err", 32'(addr_err), 32'(ee_m[s]));
        chk("par_err", 32'(par_err), 32'(ep_m[s]));
        chk("dout", dout, hold);
        if (rvalid || addr_err)
            ev_q.push_back('{d: dout, rv: rvalid, er: addr_err, pe: par_err});
    end

    task automatic op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] b);
        req = 1'b1; we = w; addr = a; din = d; be = b;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ev(string nm, int idx, logic [DW-1:0] d, bit rv, bit er);
        if (idx >= ev_q.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: missing output event %0d, got %0d events", nm, idx, ev_q.size());
        end else begin
            chk({nm, "_dout"}, ev_q[idx].d, d);
            chk({nm, "_rvalid"}, 32'(ev_q[idx].rv), 32'(rv));
            chk({nm, "_addr_err"}, 32'(ev_q[idx].er), 32'(er));
        end
    endtask

    task automatic init_check(string nm);
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk); #1;
            chk(nm, 32'(ready), 32'(k >= 12));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        init_check("init_ready_edge");

        ev_q.delete();
        for (int a = 0; a < DEPTH; a++) op(0, AW'(a), '0, '0);
        idle(4);
        chk("init_read_count", ev_q.size(), 12);
        for (int a = 0; a < DEPTH; a++) chk_ev("init_read", a, 32'h0, 1, 0);

        ev_q.delete();
        op(1, 4'd3, 32'hA5A5A5A5, 4'hF);
        op(1, 4'd3, 32'h00001234, 4'h3);
        op(0, 4'd3, '0, '0);
        idle(4);
        chk_ev("byte_en", 0, 32'hA5A51234, 1, 0);

        ev_q.delete();
        op(1, 4'd5, 32'h11, 4'hF);
        op(1, 4'd6, 32'h22, 4'hF);
        op(1, 4'd7, 32'h33, 4'hF);
        op(0, 4'd5, '0, '0);
        op(0, 4'd6, '0, '0);
        op(0, 4'd7, '0, '0);
        idle(4);
        chk_ev("stream0", 0, 32'h11, 1, 0);
        chk_ev("stream1", 1, 32'h22, 1, 0);
        chk_ev("stream2", 2, 32'h33, 1, 0);

        ev_q.delete();
        op(1, 4'd9, 32'hDEADBEEF, 4'hF);
        op(0, 4'd9, '0, '0);
        idle(4);
        chk_ev("wr_then_rd", 0, 32'hDEADBEEF, 1, 0);

        ev_q.delete();
        op(0, 4'd13, '0, '0);
        idle(3);
        op(1, 4'd13, 32'hFFFFFFFF, 4'hF);
        idle(4);
        chk_ev("oor_read", 0, 32'h0, 1, 1);
        chk_ev("oor_write", 1, 32'h0, 0, 1);

        ev_q.delete();
        op(1, 4'd5, 32'hFFFFFFFF, 4'h0);
        op(0, 4'd5, '0, '0);
        idle(4);
        chk_ev("be_zero", 0, 32'h11, 1, 0);

        for (int i = 0; i < 400; i++) begin
            req  = 1'($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            addr = AW'($urandom_range(0, 15));
            be   = NB'($urandom);
            din  = $urandom;
            @(posedge clk); #1;
        end
        req = 1'b0;
        idle(4);

        ev_q.delete();
        op(0, 4'd4, '0, '0);
        rstn = 1'b0;
        idle(2);
        chk("rst_mid_read_lost", ev_q.size(), 0);
        chk("rst_ready_low", 32'(ready), 32'h0);
        rstn = 1'b1;
        init_check("reinit_ready_edge");
        ev_q.delete();
        op(0, 4'd3, '0, '0);
        idle(4);
        chk_ev("rezeroed", 0, 32'h0, 1, 0);

`ifdef SRAM_PARITY_EN
        ev_q.delete();
        op(1, 4'd2, 32'h0F0F0F0F, 4'hF);
        dut.inject_par_flip(4'd2, 1);
        m_pbad[2][1] = 1'b1;
        op(0, 4'd2, '0, '0);
        idle(4);
        chk_ev("par_flip", 0, 32'h0F0F0F0F, 1, 0);
        if (ev_q.size() > 0) chk("par_flip_par_err", 32'(ev_q[0].pe), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
